// File: rtl/aes_pkg.sv
// aes_pkg -- shared types, constants and GF(2^8) helpers for the AES-128
// inverse cipher.
//   state_t       : 128-bit AES state, byte 0 in bits [127:120], column-major
//   round_idx_t   : 4-bit round-key index (0..10)
//   fsm_t         : controller states of aes_dec_core
//   gf_xtime      : multiply by x modulo x^8+x^4+x^3+x+1
//   gf_mul        : general GF(2^8) multiply
//   inv_shift_rows, inv_mix_columns : whole-state inverse round transforms
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [3:0]   round_idx_t;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; each step doubles the running multiplicand.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] term;
        prod = 8'h00;
        term = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ term;
            term = gf_xtime(term);
        end
        return prod;
    endfunction

    // Row r of the state is rotated right by r byte positions.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c - row + 4) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox -- combinational AES inverse S-box.
//   cipher_byte : byte entering InvSubBytes
//   plain_byte  : substituted byte
// Computed rather than tabulated: undo the affine transform, then take the
// multiplicative inverse as b^254 (with 0 mapping to 0).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] cipher_byte,
    output logic [7:0] plain_byte
);

    logic [7:0] pre_inv;
    logic [7:0] sq;
    logic [7:0] acc;

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
    assign pre_inv = {cipher_byte[6:0], cipher_byte[7]}
                   ^ {cipher_byte[4:0], cipher_byte[7:5]}
                   ^ {cipher_byte[1:0], cipher_byte[7:2]}
                   ^ 8'h05;

    // b^254 = b^2 * b^4 * ... * b^128: square repeatedly, accumulate each power.
    always_comb begin
        sq  = pre_inv;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        plain_byte = acc;
    end

endmodule

// File: rtl/aes_dec_core.sv
// aes_dec_core -- iterative AES-128 inverse cipher, one round per clock.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : ciphertext handshake (ready only while idle)
//   ciphertext [127:0]   : block to decrypt, sampled at the accept edge
//   rk_idx [3:0]         : round key requested from the external key store
//   round_key [127:0]    : key for rk_idx, valid in the same cycle
//   out_valid/out_ready  : plaintext handshake, result held until taken
//   plaintext [127:0]    : decrypted block
module aes_dec_core
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    localparam round_idx_t LAST_IDX    = round_idx_t'(NR);
    localparam round_idx_t FIRST_ROUND = round_idx_t'(NR - 1);

    fsm_t       fsm;
    fsm_t       fsm_next;
    round_idx_t cnt;
    state_t     state_reg;

    state_t shifted;
    state_t subbed;
    state_t keyed;
    state_t mixed;

    // Shared round datapath: ROUND takes the mixed result, FINAL the keyed one.
    assign shifted = inv_shift_rows(state_reg);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .cipher_byte (shifted[127 - 8 * i -: 8]),
            .plain_byte  (subbed[127 - 8 * i -: 8])
        );
    end

    assign keyed     = subbed ^ round_key;
    assign mixed     = inv_mix_columns(keyed);
    assign plaintext = state_reg;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        fsm_next  = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = LAST_IDX;
        unique case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_next = ROUND;
            end
            ROUND: begin
                rk_idx = cnt;
                if (cnt == round_idx_t'(1)) fsm_next = FINAL;
            end
            FINAL: begin
                rk_idx   = '0;
                fsm_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            cnt <= '0;
            // NOTE: state_reg is a plain register, not a memory array, so it is
            // cleared here and plaintext reads zero straight after reset.
            state_reg <= '0;
        end else begin
            fsm <= fsm_next;
            unique case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= ciphertext ^ round_key;
                        cnt       <= FIRST_ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= mixed;
                    cnt       <= cnt - 4'd1;
                end
                FINAL: state_reg <= keyed;
                DONE:  ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_core.sv
module tb_aes_dec_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    logic [127:0] rk_table [0:10];
    logic [7:0]   sbox [0:255];
    logic [127:0] exp_q [$];

    int total = 0;
    int bad = 0;
    int outputs_seen = 0;
    int outputs_expected = 0;
    bit rand_ready = 1'b0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    always #5 clk = ~clk;

    // Key store model: combinational lookup by rk_idx.
    assign round_key = (rk_idx <= 4'd10) ? rk_table[rk_idx] : 128'h0;

    aes_dec_core #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .rk_idx     (rk_idx),
        .round_key  (round_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    // Polynomial product, then long division by 0x11b.
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int aa;
        p  = 0;
        aa = int'(a);
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (aa << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
        return p[7:0];
    endfunction

    // Forward S-box from its definition: inverse by search, then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] x;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (v != 0 && mul(x, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic load_keys(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = mul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_table[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // Forward cipher over the loaded key table; the DUT must invert it.
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk_table[0][127 - 8 * i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r + 4 * c] = t[r + 4 * ((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    s[4 * c]     = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
                    s[4 * c + 3] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_table[rnd][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'd1);
    endtask

    // Offers one block; returns one time unit after the accept edge.
    task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                        input bit expect_out, output logic [3:0] accept_rk);
        wait_idle();
        load_keys(key);
        ciphertext = ct;
        in_valid   = 1'b1;
        #1;
        accept_rk = rk_idx;
        if (expect_out) begin
            exp_q.push_back(pt);
            outputs_expected++;
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Monitor: every accepted output is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                outputs_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h required none", plaintext);
                end else begin
                    check("plaintext", plaintext, exp_q.pop_front());
                end
            end
        end
    end

    // Random consumer backpressure while rand_ready is set.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]   acc_rk;
        logic [3:0]   trace [$];
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           lat;
        int           seen;
        int           n;

        build_sbox();
        load_keys(128'h0);
        rst        = 1'b1;
        in_valid   = 1'b0;
        ciphertext = 128'h0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_in_ready",  128'(in_ready),  128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_plaintext", plaintext,       128'h0);
        check("reset_rk_idx",    128'(rk_idx),    128'd10);

        // Known-answer C.1 with latency and round-key index trace.
        send(C1_KEY, C1_CT, C1_PT, 1'b1, acc_rk);
        trace.push_back(acc_rk);
        lat = 1;
        while (!out_valid && lat < 40) begin
            trace.push_back(rk_idx);
            @(posedge clk); #1;
            lat++;
        end
        check("c1_latency", 128'(lat), 128'd11);
        check("rk_trace_len", 128'(trace.size()), 128'd11);
        for (int i = 0; i < trace.size() && i < 11; i++)
            check($sformatf("rk_trace_%0d", i), 128'(trace[i]), 128'(10 - i));

        // Known-answer App. B.
        send(B_KEY, B_CT, B_PT, 1'b1, acc_rk);

        // Ciphertext overwritten right after acceptance must not matter.
        send(C1_KEY, C1_CT, C1_PT, 1'b1, acc_rk);
        ciphertext = '1;

        // Backpressure: result held, no new input accepted.
        wait_idle();
        out_ready = 1'b0;
        send(B_KEY, B_CT, B_PT, 1'b1, acc_rk);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_out_valid_rise", 128'(out_valid), 128'd1);
        for (int i = 0; i < 20; i++) begin
            check("bp_plaintext_hold", plaintext, B_PT);
            check("bp_in_ready_low", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);

        // Mid-operation reset aborts the block.
        send(C1_KEY, C1_CT, C1_PT, 1'b0, acc_rk);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready",  128'(in_ready), 128'd1);
        check("abort_plaintext", plaintext,      128'h0);
        check("abort_rk_idx",    128'(rk_idx),   128'd10);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", 128'(seen), 128'd0);
        send(C1_KEY, C1_CT, C1_PT, 1'b1, acc_rk);

        // Random keys and plaintexts with random consumer stalls.
        wait_idle();
        rand_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            wait_idle();
            load_keys(key);
            ct = encrypt(pt);
            send(key, ct, pt, 1'b1, acc_rk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        check("output_count", 128'(outputs_seen), 128'(outputs_expected));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_dec_core.md
AES_DEC_CORE -- requirements
Module: aes_dec_core

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: ciphertext offered.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept ciphertext.
REQ-005 SHALL have port ciphertext, input, 128 bits: ciphertext block; byte 0 = bits [127:120], column-major as in FIPS-197.
REQ-006 SHALL have port rk_idx, output, 4 bits: index (0..10) of the round key requested from the external key store.
REQ-007 SHALL have port round_key, input, 128 bits: round key for rk_idx, valid combinationally in the same cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: plaintext valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts plaintext.
REQ-010 SHALL have port plaintext, output, 128 bits: decrypted block, same byte ordering as ciphertext.
REQ-011 SHALL have parameter NR, default 10, meaning number of AES rounds; AES-128 only.

Function
REQ-012 SHALL implement the FIPS-197 AES-128 inverse cipher iteratively: one round per clock.
REQ-013 SHALL use FSM states IDLE, ROUND, FINAL, DONE.
REQ-014 IDLE: in_ready=1 and rk_idx=NR; on in_valid&in_ready, state_reg <= ciphertext XOR round_key; round counter <= NR-1; go to ROUND.
REQ-015 ROUND: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) XOR round_key), with rk_idx = counter.
REQ-016 ROUND: counter decrements each cycle; when counter==1, go to FINAL next.
REQ-017 FINAL: rk_idx=0; state_reg <= InvSubBytes(InvShiftRows(state_reg)) XOR round_key, with no InvMixColumns; go to DONE.
REQ-018 DONE: out_valid=1 and plaintext=state_reg, held stable until out_valid&out_ready; then go to IDLE.
REQ-019 Latency: if the handshake occurs in cycle T, out_valid SHALL be high from cycle T+11 onward; throughput is one block per 12 cycles at minimum.
REQ-020 in_ready SHALL be 0 in all states other than IDLE; a same-cycle input accept in DONE is not supported.
REQ-021 ciphertext SHALL be sampled only at the accept edge; later changes SHALL NOT affect the result.
REQ-022 round_key SHALL be used only in the cycle rk_idx names it; rk_idx outside ROUND/FINAL SHALL equal NR.
REQ-023 If out_ready is held low, DONE SHALL persist indefinitely with plaintext unchanged.
REQ-024 All GF(2^8) arithmetic SHALL reduce modulo x^8+x^4+x^3+x+1; InvMixColumns SHALL use coefficients {0e,0b,0d,09}.

Reset
REQ-025 When rst=1 at a rising edge: FSM -> IDLE; counter -> 0; state_reg -> 0.
REQ-026 After reset: in_ready=1, out_valid=0, plaintext=0, rk_idx=NR.
REQ-027 Reset asserted mid-operation (ROUND, FINAL, or DONE) SHALL abort the block with no output; rst SHALL take priority over in_valid.

Structure
REQ-028 Package aes_pkg SHALL hold: the state_t typedef (128-bit); NR; the round-index typedef (4-bit); and functions inv_shift_rows, gf_xtime, gf_mul, inv_mix_columns.
REQ-029 Sub-module aes_inv_sbox SHALL provide a combinational 8-bit inverse S-box, instantiated 16 times; the FSM and datapath remain in aes_dec_core.

Verification
REQ-030 Bench SHALL model the key store as a table of 11 expanded round keys, driven combinationally from rk_idx.
REQ-031 FIPS-197 App. C.1 case: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept.
REQ-032 FIPS-197 App. B case: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
REQ-033 Backpressure: out_ready held 0 for 20 cycles after out_valid -> plaintext stable and in_ready=0 throughout; releasing out_ready -> in_ready=1 on the next cycle.
REQ-034 Mid-operation reset: rst pulsed at cycle T+5 -> out_valid never rises; a subsequent C.1 run produces the correct pt.
REQ-035 rk_idx trace: for one block, the sequence observed at the cycle of each state_reg update SHALL be 10,9,8,...,1,0.
REQ-036 Input mutation: ciphertext changed to all-ones one cycle after accept -> result still equals the C.1 plaintext.
